// File: rtl/poly_compress.sv
// poly_compress: reduces coefficient pairs mod q=3329, compresses each to D bits and buffers them
// in a credit-controlled FIFO. Define POLY_COMPRESS_ADDR_CHECK_EN to enable the address-order checker.
module poly_compress #(
    parameter int unsigned D          = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [6:0]   in_addr,
    input  logic [15:0]  in_data_a,
    input  logic [15:0]  in_data_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [6:0]   out_addr,
    output logic [D-1:0] out_a,
    output logic [D-1:0] out_b,
    output logic         done,
    output logic         err
);
    localparam int unsigned Q         = 3329;
    localparam int unsigned HALF_Q    = 1664;
    localparam int unsigned BARRETT_M = 5039;      // floor(2^24 / q)
    localparam int unsigned DIV_M     = 10321340;  // ceil(2^35 / q), exact for numerators < 2^23
    localparam int unsigned DIV_S     = 35;
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned SW        = AW + 2;
    localparam int unsigned PAIRS     = 128;

    typedef struct packed {
        logic [6:0]   addr;
        logic [D-1:0] a;
        logic [D-1:0] b;
    } entry_t;

    // Quotient estimate floor(x/q), exact or one low for 16-bit x
    function automatic logic [4:0] quot_est(input logic [15:0] x);
        logic [28:0] p;
        p = 29'(x) * 29'(BARRETT_M);
        return 5'(p >> 24);
    endfunction

    function automatic logic [11:0] reduce(input logic [15:0] x, input logic [4:0] t);
        logic [16:0] r0;
        r0 = 17'(x) - 17'(t) * 17'(Q);
        if (r0 >= 17'(Q)) begin
            r0 = r0 - 17'(Q);
        end
        return 12'(r0);
    endfunction

    // floor(((r << D) + (q-1)/2) / q) mod 2^D via reciprocal multiply
    function automatic logic [D-1:0] compress(input logic [11:0] r);
        logic [47:0] n;
        logic [47:0] p;
        n = (48'(r) << D) + 48'(HALF_Q);
        p = n * 48'(DIV_M);
        return D'(p >> DIV_S);
    endfunction

    logic          accept;
    logic          v1, v2, v3;
    logic [6:0]    addr1, addr2, addr3;
    logic [15:0]   xa1, xb1;
    logic [4:0]    ta1, tb1;
    logic [11:0]   ra2, rb2;
    logic [D-1:0]  ca3, cb3;

    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic [SW-1:0] credit_used;
    logic          push, pop;
    logic [7:0]    pair_cnt;

    assign accept = in_valid & in_ready;
    assign push   = set & v3;
    assign pop    = out_valid & out_ready;

    // A pop this cycle frees a slot in time for the pair accepted now
    assign credit_used = SW'(count) + SW'(v1) + SW'(v2) + SW'(v3) - SW'(pop);
    assign in_ready    = reset & set & (credit_used < SW'(FIFO_DEPTH));
    assign out_valid   = set & (count != '0);

    assign head     = mem[rptr];
    assign out_addr = (count != '0) ? head.addr : '0;
    assign out_a    = (count != '0) ? head.a    : '0;
    assign out_b    = (count != '0) ? head.b    : '0;

    // Three-stage reduce/compress pipeline, both lanes in lockstep
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            addr1 <= '0;
            addr2 <= '0;
            addr3 <= '0;
            xa1   <= '0;
            xb1   <= '0;
            ta1   <= '0;
            tb1   <= '0;
            ra2   <= '0;
            rb2   <= '0;
            ca3   <= '0;
            cb3   <= '0;
        end else if (set) begin
            v1    <= accept;
            addr1 <= in_addr;
            xa1   <= in_data_a;
            xb1   <= in_data_b;
            ta1   <= quot_est(in_data_a);
            tb1   <= quot_est(in_data_b);
            v2    <= v1;
            addr2 <= addr1;
            ra2   <= reduce(xa1, ta1);
            rb2   <= reduce(xb1, tb1);
            v3    <= v2;
            addr3 <= addr2;
            ca3   <= compress(ra2);
            cb3   <= compress(rb2);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{addr: addr3, a: ca3, b: cb3};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Delivered-pair counter; start takes priority over a coincident transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_cnt <= '0;
            done     <= 1'b0;
        end else if (set) begin
            if (start) begin
                pair_cnt <= '0;
                done     <= 1'b0;
            end else if (pop && !done) begin
                pair_cnt <= pair_cnt + 8'd1;
                if (pair_cnt == 8'(PAIRS - 1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

`ifdef POLY_COMPRESS_ADDR_CHECK_EN
    logic [6:0] exp_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_idx <= '0;
            err     <= 1'b0;
        end else if (set) begin
            if (start) begin
                exp_idx <= '0;
                err     <= 1'b0;
            end else if (accept) begin
                exp_idx <= exp_idx + 7'd1;
                if (in_addr != exp_idx) begin
                    err <= 1'b1;
                end
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/poly_compress.md
Name: poly_compress

Overview:
- Downstream consumer of the accumulator readout stream: takes coefficient pairs (addr, data_a, data_b) as the accumulator drains its 128-entry polynomial.
- Each 16-bit coefficient is fully reduced mod q=3329, then compressed to D bits: Compress_D(x) = round(2^D*x/q) mod 2^D.
- Results are buffered in a small FIFO and presented on a valid/ready port to the packer/encoder stage.
- Counts 128 pairs per polynomial and flags completion.

Parameters:
- D, 4, compressed coefficient width (legal 1..11; 4/5 for v, 10/11 for u).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- set  in  1  global enable; 0 freezes all state.
- start  in  1  single-cycle pulse; clears pair counter and done.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_addr  in  7  pair index 0..127.
- in_data_a  in  16  even coefficient, unsigned.
- in_data_b  in  16  odd coefficient, unsigned.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_addr  out  7  pair index of head.
- out_a  out  D  compressed even coefficient.
- out_b  out  D  compressed odd coefficient.
- done  out  1  128 pairs delivered since last start/reset.
- err  out  1  address-order error (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (reset=0, async): pipeline valids, FIFO pointers/count, pair counter, done, err all 0. in_ready=0 while reset is asserted. out_valid=0. out_addr/out_a/out_b=0.
- Accept: transfer when in_valid & in_ready & set.
- in_ready = set & (fifo_count + pipeline_occupancy < FIFO_DEPTH). This is credit-based, so the FIFO never overflows and no in-flight pair is dropped.
- Pipeline: 3 register stages, both lanes identical.
  - S1: t = (x*5039)>>24, a 16x13 multiply.
  - S2: r = x - t*3329; if r >= 3329 then r -= 3329. One correction suffices, because t is exact or low by one for x < 2^16.
  - S3: c = floor((r<<D) + 1664)/3329) mod 2^D. The divide is done by multiply-shift and must be exact for all r in [0,3328].
- FIFO write at end of S3.
- Latency: accepted pair appears at out_valid exactly 4 clocks after accept when the FIFO is empty.
- Throughput: 1 pair/clock when out_ready is held 1.
- FIFO simultaneous push and pop: count unchanged, both happen.
- Pop when empty: ignored.
- out_* holds the head value stable while out_valid & !out_ready.
- Pair counter (8 bit): increments on each output transfer (out_valid & out_ready).
  - On reaching 128, done=1 and the counter holds.
  - Further transfers while done=1 do not change the counter.
- start=1: counter := 0, done := 0, next cycle. start does not flush the pipeline or FIFO.
- start coincident with an output transfer: start wins; counter=0.
- set=0: all registers hold; in_ready=0 and out_valid=0 combinationally. Resuming set=1 restores the prior state exactly.
- Reset asserted mid-polynomial: all in-flight data discarded.

Optional Feature:
- Macro: POLY_COMPRESS_ADDR_CHECK_EN.
- Enabled:
  - An expected-index register (7 bit, reset 0, cleared by start) increments on each accept.
  - An accept with in_addr != expected sets err=1 (sticky until start/reset).
  - Data is still processed normally.
- Disabled: no checker logic; err tied to 0.

Test Plan:
- Single-value mapping, D=4: in_data_a=1665 -> out_a=8. 3329 -> 0. 3328 -> 0 (16 wraps). 832 -> 4. 65535 -> 11. Each appears exactly 4 clocks after accept.
- D=10 build: in 1 -> 0. 2 -> 1. 1665 -> 512. 0 -> 0.
- Full stream: 128 pairs, in_data_a=2k*3, in_data_b=(2k+1)*3 for k=0..127, out_ready=1. Required:
  - out_addr increments 0..127 with no gaps.
  - Every out_a/out_b equals the software Compress_D reference.
  - done rises the cycle after the 128th transfer.
- Backpressure: out_ready=0 with in_valid held high. Required:
  - in_ready drops after exactly FIFO_DEPTH accepts.
  - No data lost.
  - Releasing out_ready drains in order.
  - Random out_ready toggling over 128 pairs gives an identical output sequence.
- Control: set=0 for 5 cycles mid-stream freezes out_* and the counter. start mid-stream clears done/counter only. Async reset mid-stream gives out_valid=0 and done=0 immediately.
- With POLY_COMPRESS_ADDR_CHECK_EN: in_addr sequence 0,1,3 -> err=1 after the third accept, held until start. A correct sequence keeps err=0.
